// File: rtl/gf_sub_word.sv
// gf_sub_word: AES SubWord, one composite-field S-box shared over 4 bytes.
// Ports: clk, rst_n, in_valid/in_ready/in_word[/inv], out_valid/out_ready/out_word, busy.
// Define GF_SUB_WORD_INV_EN to add port inv and the inverse S-box path.
module gf_sub_word (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
`ifdef GF_SUB_WORD_INV_EN
  input  logic        inv,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Tower GF(((2^2)^2)^2), normal bases at every level.
  // GF(4): {W, W^2}, bit1 = W coef. One = 2'b11.
  // GF(16): {Z, Z^4}, Z^2+Z+N=0, N=W^2.
  // GF(256): {Y, Y^16}, Y^2+Y+M=0, M found below.
  localparam logic [1:0] GF4_N = 2'b01;

  function automatic logic [1:0] gf4_mul(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic s;
    s = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ s, (a[0] & b[0]) ^ s};
  endfunction

  // Squaring and inversion are both a swap in GF(4).
  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    return {a[0], a[1]};
  endfunction

  function automatic logic [3:0] gf16_mul(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [1:0] s;
    s = gf4_mul(gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]), GF4_N);
    return {gf4_mul(a[3:2], b[3:2]) ^ s, gf4_mul(a[1:0], b[1:0]) ^ s};
  endfunction

  // A * conj(A) lands in the subfield; invert there, scale the conjugate.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [1:0] c, ci;
    c  = gf4_mul(a[3:2], a[1:0]) ^ gf4_mul(gf4_sq(a[3:2] ^ a[1:0]), GF4_N);
    ci = gf4_sq(c);
    return {gf4_mul(ci, a[1:0]), gf4_mul(ci, a[3:2])};
  endfunction

  function automatic logic [7:0] gf256_mul(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [3:0] m
  );
    logic [3:0] s;
    s = gf16_mul(gf16_mul(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]), m);
    return {gf16_mul(a[7:4], b[7:4]) ^ s, gf16_mul(a[3:0], b[3:0]) ^ s};
  endfunction

  function automatic logic [7:0] gf256_inv(
    input logic [7:0] a,
    input logic [3:0] m
  );
    logic [3:0] x, c, ci;
    x  = a[7:4] ^ a[3:0];
    c  = gf16_mul(a[7:4], a[3:0]) ^ gf16_mul(gf16_mul(x, x), m);
    ci = gf16_inv(c);
    return {gf16_mul(ci, a[3:0]), gf16_mul(ci, a[7:4])};
  endfunction

  // M must not be of the form y^2+y, so Y^2+Y+M stays irreducible.
  function automatic logic [3:0] find_m();
    logic [15:0] hit;
    logic [3:0]  y, v, m;
    hit = '0;
    for (int i = 0; i < 16; i++) begin
      y      = i[3:0];
      v      = gf16_mul(y, y) ^ y;
      hit[v] = 1'b1;
    end
    m = '0;
    for (int i = 15; i > 0; i--)
      if (!hit[i]) m = i[3:0];
    return m;
  endfunction

  localparam logic [3:0] GF16_M = find_m();

  function automatic logic [7:0] mat_apply(
    input logic [63:0] mat,
    input logic [7:0]  v
  );
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = r ^ mat[8*i +: 8];
    return r;
  endfunction

  // Column i = r^i, r a tower root of x^8+x^4+x^3+x+1.
  function automatic logic [63:0] find_to_twr(input logic [3:0] m);
    logic [7:0]  c, r, p2, p3, p4, p8, pw;
    logic [63:0] cols;
    r = '0;
    for (int i = 255; i > 1; i--) begin
      c  = i[7:0];
      p2 = gf256_mul(c, c, m);
      p3 = gf256_mul(p2, c, m);
      p4 = gf256_mul(p2, p2, m);
      p8 = gf256_mul(p4, p4, m);
      if ((p8 ^ p4 ^ p3 ^ c ^ 8'hFF) == 8'h00) r = c;
    end
    cols = '0;
    pw   = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      cols[8*i +: 8] = pw;
      pw = gf256_mul(pw, r, m);
    end
    return cols;
  endfunction

  // Inverse basis change: preimage of each tower basis vector.
  function automatic logic [63:0] find_to_std(input logic [63:0] fwd);
    logic [7:0]  t;
    logic [63:0] cols;
    cols = '0;
    for (int s = 0; s < 256; s++) begin
      t = mat_apply(fwd, s[7:0]);
      for (int j = 0; j < 8; j++)
        if (t == (8'h01 << j)) cols[8*j +: 8] = s[7:0];
    end
    return cols;
  endfunction

  localparam logic [63:0] TO_TWR = find_to_twr(GF16_M);
  localparam logic [63:0] TO_STD = find_to_std(TO_TWR);

  function automatic logic [7:0] fwd_affine(input logic [7:0] s);
    return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]}
             ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
  endfunction

`ifdef GF_SUB_WORD_INV_EN
  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]}
         ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction
`endif

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] work_q, work_d;
  logic        accept;
  logic [7:0]  sub_in, pre, raw, sub_out;

`ifdef GF_SUB_WORD_INV_EN
  logic        inv_q, inv_d;
`endif

  assign sub_in = work_q[{idx_q, 3'b000} +: 8];
  assign raw    = mat_apply(TO_STD,
                    gf256_inv(mat_apply(TO_TWR, pre), GF16_M));

`ifdef GF_SUB_WORD_INV_EN
  assign pre     = inv_q ? inv_affine(sub_in) : sub_in;
  assign sub_out = inv_q ? raw : fwd_affine(raw);
`else
  assign pre     = sub_in;
  assign sub_out = fwd_affine(raw);
`endif

  assign in_ready  = (state_q == IDLE) |
                     ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SUB) | (state_q == DONE);
  assign out_word  = work_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
`ifdef GF_SUB_WORD_INV_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      SUB: begin
        work_d[{idx_q, 3'b000} +: 8] = sub_out;
        if (idx_q == 2'd3) state_d = DONE;
        else               idx_d   = idx_q + 2'd1;
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      state_d = SUB;
      idx_d   = '0;
      work_d  = in_word;
`ifdef GF_SUB_WORD_INV_EN
      inv_d   = inv;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      work_q  <= '0;
`ifdef GF_SUB_WORD_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
`ifdef GF_SUB_WORD_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

endmodule
